// File: rtl/simon_key_sched.sv
// simon_key_sched: SIMON 32/64 key expansion into a 32-entry buffer, streamed to the round core in encrypt or decrypt order.
module simon_key_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] key_i,
  input  logic        load_i,
  input  logic        mode_i,
  input  logic        start_i,
  output logic [15:0] rk_data_o,
  output logic [4:0]  rk_idx_o,
  output logic        rk_valid_o,
  input  logic        rk_ready_i,
  output logic        rk_last_o,
  output logic        keys_ready_o,
  output logic        busy_o
);
  typedef enum logic [1:0] {IDLE, EXPAND, READY, STREAM} state_t;
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  state_t      state, state_nx;
  logic [15:0] kbuf [32];
  logic [4:0]  i, idx;
  logic        mode;
  logic [15:0] t, k_new;
  logic [5:0]  zi;
  // z0 is written with index 0 leftmost, so sequence position p lives at bit 61-p
  assign zi    = 6'd61 - ({1'b0, i} - 6'd4);
  assign t     = {kbuf[i - 5'd1][2:0], kbuf[i - 5'd1][15:3]} ^ kbuf[i - 5'd3];
  assign k_new = ~kbuf[i - 5'd4] ^ t ^ {t[0], t[15:1]} ^ {15'd0, Z0[zi]} ^ 16'h0003;
  assign rk_valid_o   = state == STREAM;
  assign rk_idx_o     = idx;
  assign rk_data_o    = rk_valid_o ? kbuf[idx] : 16'd0;
  assign rk_last_o    = rk_valid_o && idx == (mode ? 5'd0 : 5'd31);
  assign keys_ready_o = state == READY || state == STREAM;
  assign busy_o       = state == EXPAND || state == STREAM;
  always_comb begin
    state_nx = load_i ? EXPAND :
               (state == EXPAND && i == 5'd31) ? READY :
               (state == READY && start_i) ? STREAM :
               (state == STREAM && rk_ready_i && rk_last_o) ? READY : state;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      i    <= 5'd0;
      idx  <= 5'd0;
      mode <= 1'b0;
    end else if (load_i) begin
      i <= 5'd4;
    end else if (state == EXPAND) begin
      i <= i + 5'd1;
    end else if (state == READY && start_i) begin
      mode <= mode_i;
      idx  <= mode_i ? 5'd31 : 5'd0;
    end else if (state == STREAM && rk_ready_i) begin
      idx <= mode ? idx - 5'd1 : idx + 5'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (load_i) begin
      kbuf[0] <= key_i[15:0];
      kbuf[1] <= key_i[31:16];
      kbuf[2] <= key_i[47:32];
      kbuf[3] <= key_i[63:48];
    end else if (state == EXPAND) begin
      kbuf[i] <= k_new;
    end
  end
endmodule

// File: tb/tb_simon_key_sched.sv
// tb_simon_key_sched: randomized checks of the SIMON 32/64 key scheduler against a behavioural schedule model.
module tb_simon_key_sched;
  logic        clk = 1'b0;
  logic        rst, load_i, mode_i, start_i, rk_ready_i;
  logic [63:0] key_i;
  logic [15:0] rk_data_o;
  logic [4:0]  rk_idx_o;
  logic        rk_valid_o, rk_last_o, keys_ready_o, busy_o;
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] ref_k [32];
  logic [15:0] cap [32];
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;

  simon_key_sched dut (
    .clk(clk), .rst(rst), .key_i(key_i), .load_i(load_i), .mode_i(mode_i),
    .start_i(start_i), .rk_data_o(rk_data_o), .rk_idx_o(rk_idx_o),
    .rk_valid_o(rk_valid_o), .rk_ready_i(rk_ready_i), .rk_last_o(rk_last_o),
    .keys_ready_o(keys_ready_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] ror(input logic [15:0] x, input int r);
    return (x >> r) | (x << (16 - r));
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic build_ref(input logic [63:0] key);
    logic [15:0] tmp;
    string zs;
    zs = "11111010001001010110000111001101111101000100101011000011100110";
    for (int j = 0; j < 4; j++) ref_k[j] = key[16*j +: 16];
    for (int j = 4; j < 32; j++) begin
      tmp = ror(ref_k[j-1], 3) ^ ref_k[j-3];
      ref_k[j] = ~ref_k[j-4] ^ tmp ^ ror(tmp, 1) ^ ((zs[j-4] == "1") ? 16'd1 : 16'd0) ^ 16'd3;
    end
  endtask

  task automatic load_key(input logic [63:0] key);
    int cnt;
    key_i = key;
    load_i = 1'b1;
    build_ref(key);
    tick;
    load_i = 1'b0;
    key_i = {$urandom, $urandom};
    vectors++;
    if (keys_ready_o !== 1'b0 || busy_o !== 1'b1 || rk_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL load_entry: ready=%b busy=%b valid=%b, required 0 1 0", keys_ready_o, busy_o, rk_valid_o);
    end
    cnt = 0;
    while (!keys_ready_o && cnt < 100) begin
      tick;
      cnt++;
    end
    vectors++;
    if (cnt !== 28) begin
      miscompares++;
      $display("FAIL expand_latency: %0d cycles, required 28", cnt);
    end
    vectors++;
    if (busy_o !== 1'b0 || rk_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_flags: busy=%b valid=%b, required 0 0", busy_o, rk_valid_o);
    end
  endtask

  task automatic run_stream(input logic m, input int stall_at, input bit rnd, input int abort_at);
    int n, cyc, stalls, ei;
    bit have_prev;
    logic [21:0] prev;
    mode_i = m;
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    mode_i = $urandom_range(0, 1);
    n = 0;
    cyc = 0;
    stalls = 0;
    have_prev = 0;
    prev = '0;
    while (n < 32 && cyc < 400) begin
      if (n == abort_at) return;
      ei = m ? 31 - n : n;
      if (n == stall_at && stalls < 5) begin
        rk_ready_i = 1'b0;
        stalls++;
      end else rk_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      vectors++;
      if (rk_valid_o !== 1'b1 || rk_idx_o !== 5'(ei) || rk_data_o !== ref_k[ei] || rk_last_o !== (n == 31)) begin
        miscompares++;
        $display("FAIL beat%0d: valid=%b idx=%0d data=%h last=%b, required 1 %0d %h %b",
                 n, rk_valid_o, rk_idx_o, rk_data_o, rk_last_o, ei, ref_k[ei], n == 31);
      end
      if (have_prev) begin
        vectors++;
        if ({rk_data_o, rk_idx_o, rk_last_o} !== prev) begin
          miscompares++;
          $display("FAIL stall_stable: %h, required %h", {rk_data_o, rk_idx_o, rk_last_o}, prev);
        end
      end
      have_prev = !rk_ready_i;
      prev = {rk_data_o, rk_idx_o, rk_last_o};
      cap[ei] = rk_data_o;
      if (rk_ready_i) n++;
      tick;
      cyc++;
    end
    rk_ready_i = 1'b1;
    vectors++;
    if (n !== 32) begin
      miscompares++;
      $display("FAIL beat_count: %0d beats, required 32", n);
    end
    vectors++;
    if (rk_valid_o !== 1'b0 || keys_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_end: valid=%b ready=%b busy=%b, required 0 1 0", rk_valid_o, keys_ready_o, busy_o);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    load_i = 1'b0;
    start_i = 1'b0;
    mode_i = 1'b0;
    rk_ready_i = 1'b1;
    key_i = '0;
    tick;
    tick;
    rst = 1'b0;
    vectors++;
    if ({rk_data_o, rk_idx_o, rk_valid_o, rk_last_o, keys_ready_o, busy_o} !== 26'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: %h, required 0", {rk_data_o, rk_idx_o, rk_valid_o, rk_last_o, keys_ready_o, busy_o});
    end
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    tick;
    vectors++;
    if (rk_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_start: valid=%b busy=%b, required 0 0", rk_valid_o, busy_o);
    end
  endtask

  task automatic test_known_vector;
    load_key(64'h1918_1110_0908_0100);
    run_stream(1'b0, -1, 0, -1);
    vectors++;
    if ({cap[0], cap[1], cap[2], cap[3], cap[4]} !== {16'h0100, 16'h0908, 16'h1110, 16'h1918, 16'h71C3}) begin
      miscompares++;
      $display("FAIL known_first5: %h %h %h %h %h, required 0100 0908 1110 1918 71c3", cap[0], cap[1], cap[2], cap[3], cap[4]);
    end
    cap[0] = 16'hxxxx;
    run_stream(1'b1, -1, 0, -1);
    vectors++;
    if (cap[0] !== 16'h0100) begin
      miscompares++;
      $display("FAIL known_decrypt_last: %h, required 0100", cap[0]);
    end
  endtask

  task automatic test_stall;
    load_key({$urandom, $urandom});
    run_stream(1'b0, 10, 0, -1);
    run_stream(1'b1, 10, 1, -1);
  endtask

  task automatic test_back_to_back;
    for (int r = 0; r < 3; r++) begin
      load_key({$urandom, $urandom});
      run_stream(1'b0, -1, 1, -1);
      run_stream(1'b1, -1, 1, -1);
    end
  endtask

  task automatic test_abort;
    logic [63:0] nk;
    load_key({$urandom, $urandom});
    run_stream(1'b0, -1, 0, 7);
    nk = {$urandom, $urandom};
    load_key(nk);
    run_stream(1'b0, -1, 0, -1);
    vectors++;
    if ({cap[3], cap[2], cap[1], cap[0]} !== nk) begin
      miscompares++;
      $display("FAIL abort_newkey: %h, required %h", {cap[3], cap[2], cap[1], cap[0]}, nk);
    end
  endtask

  task automatic test_start_ignored;
    bit seen;
    int cnt;
    key_i = {$urandom, $urandom};
    build_ref(key_i);
    load_i = 1'b1;
    tick;
    load_i = 1'b0;
    repeat (5) tick;
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    seen = 0;
    cnt = 0;
    while (cnt < 30) begin
      seen |= rk_valid_o;
      tick;
      cnt++;
    end
    vectors++;
    if (seen !== 1'b0 || keys_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL start_in_expand: valid_seen=%b ready=%b, required 0 1", seen, keys_ready_o);
    end
    key_i = {$urandom, $urandom};
    build_ref(key_i);
    load_i = 1'b1;
    start_i = 1'b1;
    tick;
    load_i = 1'b0;
    start_i = 1'b0;
    vectors++;
    if (keys_ready_o !== 1'b0 || busy_o !== 1'b1 || rk_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL load_start_same: ready=%b busy=%b valid=%b, required 0 1 0", keys_ready_o, busy_o, rk_valid_o);
    end
    seen = 0;
    cnt = 0;
    while (cnt < 32) begin
      seen |= rk_valid_o;
      tick;
      cnt++;
    end
    vectors++;
    if (seen !== 1'b0 || keys_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL load_start_nostream: valid_seen=%b ready=%b, required 0 1", seen, keys_ready_o);
    end
    run_stream(1'b1, -1, 1, -1);
  endtask

  task automatic test_reset_mid;
    bit seen;
    key_i = {$urandom, $urandom};
    load_i = 1'b1;
    tick;
    load_i = 1'b0;
    repeat (12) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    vectors++;
    if ({rk_data_o, rk_idx_o, rk_valid_o, rk_last_o, keys_ready_o, busy_o} !== 26'd0) begin
      miscompares++;
      $display("FAIL reset_mid: %h, required 0", {rk_data_o, rk_idx_o, rk_valid_o, rk_last_o, keys_ready_o, busy_o});
    end
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    seen = 0;
    repeat (40) begin
      seen |= rk_valid_o | keys_ready_o | busy_o;
      tick;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_then_start: activity=%b, required 0", seen);
    end
  endtask

  initial begin
    test_reset;
    test_known_vector;
    test_stall;
    test_back_to_back;
    test_abort;
    test_start_ignored;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/simon_key_sched.md
SIMON_KEY_SCHED -- requirements
Module: simon_key_sched

Interface
REQ-001 The block SHALL have no parameters; the cipher is fixed to SIMON 32/64 (n=16, m=4, T=32, sequence z0).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 key_i  input  64  master key; key_i[15:0]=k0, [31:16]=k1, [47:32]=k2, [63:48]=k3.
REQ-005 load_i  input  1  one-cycle strobe; samples key_i and starts expansion.
REQ-006 mode_i  input  1  0=encrypt order (k0..k31), 1=decrypt order (k31..k0); sampled with start_i.
REQ-007 start_i  input  1  one-cycle strobe; starts one round-key stream.
REQ-008 rk_data_o  output  16  current round key.
REQ-009 rk_idx_o  output  5  index of rk_data_o in the schedule.
REQ-010 rk_valid_o  output  1  rk_data_o/rk_idx_o/rk_last_o are valid.
REQ-011 rk_ready_i  input  1  consumer (round core) accepts the beat.
REQ-012 rk_last_o  output  1  final beat of the stream.
REQ-013 keys_ready_o  output  1  all 32 round keys are computed and held.
REQ-014 busy_o  output  1  high in EXPAND or STREAM.

Function
REQ-015 The block SHALL hold a 32x16 round-key buffer and have states IDLE, EXPAND, READY and STREAM.
REQ-016 On the edge sampling load_i=1 (any state), the block SHALL write k0..k3 from key_i, set i=4, clear keys_ready_o, drop rk_valid_o and enter EXPAND.
REQ-017 In EXPAND, each edge SHALL write k[i] = ~k[i-4] ^ t ^ ror(t,1) ^ z0[i-4] ^ 16'h0003, where t = ror(k[i-1],3) ^ k[i-3], then increment i.
REQ-018 z0 SHALL be 62'b11111010001001010110000111001101111101000100101011000011100110, with bit index 0 as the leftmost character; only indices 0..27 are used.
REQ-019 Writing k31 SHALL move the state to READY, so keys_ready_o rises exactly 28 cycles after the load edge.
REQ-020 In READY, start_i=1 SHALL latch mode_i, set idx to 0 (encrypt) or 31 (decrypt), and enter STREAM with rk_valid_o=1 from the next cycle.
REQ-021 In STREAM, rk_data_o SHALL equal buffer[idx], and rk_idx_o SHALL equal idx.
REQ-022 A beat transfers only when rk_valid_o and rk_ready_i are both high; idx then increments (encrypt) or decrements (decrypt).
REQ-023 While rk_valid_o=1 and rk_ready_i=0, all rk_* outputs SHALL stay stable.
REQ-024 rk_last_o SHALL be high only when rk_valid_o=1 and idx is 31 (encrypt) or 0 (decrypt).
REQ-025 The rk_last_o transfer SHALL return the block to READY with rk_valid_o=0 on the next cycle; keys remain valid for further streams.
REQ-026 start_i SHALL be ignored in IDLE, EXPAND and STREAM.
REQ-027 If load_i and start_i are high in the same cycle, load_i SHALL win.
REQ-028 load_i during STREAM SHALL abort the stream; rk_valid_o=0 from the next cycle and no further beats are emitted.
REQ-029 load_i during EXPAND SHALL restart expansion from the new key_i.
REQ-030 busy_o SHALL be high in EXPAND and STREAM, and low in IDLE and READY.

Reset
REQ-031 rst=1 SHALL force IDLE, i=0 and idx=0, with all outputs 0 (rk_data_o, rk_idx_o, rk_valid_o, rk_last_o, keys_ready_o, busy_o) on the next cycle, regardless of state.
REQ-032 Buffer contents need not be reset; in IDLE, rk_data_o SHALL be forced to 0.
REQ-033 Reset mid-expansion or mid-stream SHALL discard all progress; a new load_i is required before start_i is honoured.

Verification
REQ-034 Load key_i=64'h1918_1110_0908_0100 -> keys_ready_o=1 exactly 28 cycles later; encrypt stream with rk_ready_i=1 gives beats 0x0100, 0x0908, 0x1110, 0x1918, 0x71C3, ..., 32 beats total, rk_last_o only on rk_idx_o=31.
REQ-035 Same key, mode_i=1 -> first beat rk_idx_o=31 (same value as the encrypt beat 31); last beat rk_idx_o=0, rk_data_o=0x0100, rk_last_o=1; keys_ready_o stays 1.
REQ-036 Encrypt stream with rk_ready_i low for 5 cycles at idx 10 -> rk_data_o/rk_idx_o frozen at idx 10; exactly 32 beats total, none repeated or skipped.
REQ-037 load_i at beat 7 of a stream -> rk_valid_o=0 and keys_ready_o=0 next cycle; keys_ready_o returns after 28 cycles, and a new stream shows the new k0..k3.
REQ-038 start_i during EXPAND -> no rk_valid_o; load_i+start_i in the same cycle in READY -> EXPAND entered, no stream.
REQ-039 rst at expansion cycle 12 -> all outputs 0 next cycle; a subsequent start_i alone produces no beats.
